// File: rtl/button_event_if.sv
//------------------------------------------------------------------------------
// Module      : button_event_if
// Description : Button level in, single-cycle UI event pulses out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface button_event_if;
    logic in;
    logic held;
    logic press;
    logic release_evt;
    logic click;
    logic long_press;
    logic repeat_evt;

    // Debounce / consumer side.
    modport master (
        output in,
        input  held,
        input  press,
        input  release_evt,
        input  click,
        input  long_press,
        input  repeat_evt
    );

    // Event generator side.
    modport slave (
        input  in,
        output held,
        output press,
        output release_evt,
        output click,
        output long_press,
        output repeat_evt
    );
endinterface

`default_nettype wire

// File: rtl/button_event.sv
//------------------------------------------------------------------------------
// Module      : button_event
// Description : Turns a debounced button level into press/release/click/
//               long-press/auto-repeat pulses. Auto-repeat is built only when
//               the macro BTN_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event #(
    parameter int LONG_CNT   = 50000000,
    parameter int REPEAT_CNT = 10000000
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    button_event_if.slave bus
);

    localparam int c_max_cnt = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int CNT_W     = $clog2(c_max_cnt) + 1;

    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CNT - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_rpt_last  = CNT_W'(REPEAT_CNT - 1);
`endif

    localparam logic [1:0] c_st_lock  = 2'd0;
    localparam logic [1:0] c_st_idle  = 2'd1;
    localparam logic [1:0] c_st_press = 2'd2;
    localparam logic [1:0] c_st_long  = 2'd3;

    generate
        if (LONG_CNT < 2 || REPEAT_CNT < 1) begin : g_param_check
            $error("button_event: LONG_CNT must be >= 2 and REPEAT_CNT >= 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_held, r_press, r_release, r_click, r_long, r_repeat;
    logic w_held, w_press, w_release, w_click, w_long, w_repeat;

    // State register; event outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_lock;
            r_cnt     <= c_cnt_zero;
            r_held    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_held    <= w_held;
            r_press   <= w_press;
            r_release <= w_release;
            r_click   <= w_click;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
        end
    end

    // Next-state and counter. Release always wins over long/repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_lock: begin
                if (!bus.in) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            c_st_idle: begin
                if (bus.in) begin
                    w_state_nxt = c_st_press;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            c_st_press: begin
                if (!bus.in) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_long_last) begin
                    w_state_nxt = c_st_long;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            c_st_long: begin
                if (!bus.in) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (r_cnt == c_rpt_last) begin
                        w_cnt_nxt = c_cnt_zero;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
`else
                    w_cnt_nxt = r_cnt;
`endif
                end
            end
            default: begin
                w_state_nxt = c_st_lock;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    // Output decode: values the event registers take on this edge.
    always_comb begin
        w_held    = (w_state_nxt == c_st_press) || (w_state_nxt == c_st_long);
        w_press   = (r_state == c_st_idle) && bus.in;
        w_release = ((r_state == c_st_press) || (r_state == c_st_long)) && !bus.in;
        w_click   = (r_state == c_st_press) && !bus.in;
        w_long    = (r_state == c_st_press) && bus.in && (r_cnt == c_long_last);
`ifdef BTN_AUTOREPEAT_EN
        w_repeat  = (r_state == c_st_long) && bus.in && (r_cnt == c_rpt_last);
`else
        w_repeat  = 1'b0;
`endif
    end

    assign bus.held        = r_held;
    assign bus.press       = r_press;
    assign bus.release_evt = r_release;
    assign bus.click       = r_click;
    assign bus.long_press  = r_long;
    assign bus.repeat_evt  = r_repeat;

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
//------------------------------------------------------------------------------
// Module      : tb_button_event
// Description : Self-checking bench for button_event (LONG_CNT=8, REPEAT_CNT=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event;

    localparam int LONG_CNT   = 8;
    localparam int REPEAT_CNT = 4;

    logic clk;
    logic reset_n;

    button_event_if bus();

    button_event #(
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int passed   = 0;
    int failures = 0;
    int step_no  = 0;

    // Reference model: tracks whether the button is armed, whether a press
    // is in progress and how many pressed samples it has lasted.
    bit m_armed = 1'b0;
    bit m_hold  = 1'b0;
    int m_len   = 0;
    bit e_held, e_press, e_release, e_click, e_long, e_repeat;

    task automatic model_clear_events();
        e_press   = 1'b0;
        e_release = 1'b0;
        e_click   = 1'b0;
        e_long    = 1'b0;
        e_repeat  = 1'b0;
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_hold  = 1'b0;
        m_len   = 0;
        model_clear_events();
        e_held  = 1'b0;
    endtask

    task automatic model_edge(input bit v);
        model_clear_events();
        if (!m_armed) begin
            if (!v) m_armed = 1'b1;
        end else if (!m_hold) begin
            if (v) begin
                m_hold  = 1'b1;
                m_len   = 1;
                e_press = 1'b1;
            end
        end else if (!v) begin
            e_release = 1'b1;
            e_click   = (m_len < LONG_CNT);
            m_hold    = 1'b0;
        end else begin
            m_len  = m_len + 1;
            e_long = (m_len == LONG_CNT);
`ifdef BTN_AUTOREPEAT_EN
            e_repeat = (m_len > LONG_CNT) && (((m_len - LONG_CNT) % REPEAT_CNT) == 0);
`endif
        end
        e_held = m_hold;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failures++;
            $error("FAIL %s step %0d: observed %0b expected %0b", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("held",       bus.held,        e_held);
        chk("press",      bus.press,       e_press);
        chk("release",    bus.release_evt, e_release);
        chk("click",      bus.click,       e_click);
        chk("long_press", bus.long_press,  e_long);
        chk("repeat",     bus.repeat_evt,  e_repeat);
    endtask

    // Drive a level, let one edge sample it, then compare just after the edge.
    task automatic step(input bit v);
        bus.in = v;
        @(posedge clk);
        model_edge(v);
        step_no++;
        #1;
        check_all();
    endtask

    task automatic steps(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset_n = 1'b1;
        #1;

        // Held through reset: locked until the button is released once.
        steps(1'b1, 20);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        // Short tap.
        steps(1'b1, 3);
        step(1'b0);
        step(1'b0);

        // Long hold with repeats, then release.
        steps(1'b1, 16);
        step(1'b0);

        // Release on the long_press boundary, then exactly LONG_CNT samples.
        steps(1'b1, 7);
        steps(1'b0, 3);
        steps(1'b1, 8);
        step(1'b0);

        // Back-to-back press immediately after release.
        steps(1'b1, 2);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        // Async reset in the middle of a long hold.
        steps(1'b1, 10);
        async_reset();
        steps(1'b1, 3);
        step(1'b0);
        steps(1'b1, 5);
        step(1'b0);

        // Randomised runs of pressed/released levels with occasional resets.
        for (int r = 0; r < 60; r++) begin
            bit lvl;
            int len;
            lvl = r[0] ? 1'b0 : 1'b1;
            len = (lvl == 1'b1) ? int'($urandom_range(1, 18)) : int'($urandom_range(1, 3));
            steps(lvl, len);
            if ($urandom_range(0, 9) == 0) async_reset();
        end
        steps(1'b0, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes a clean, debounced button level from the debounce stage.
- Converts it into single-cycle event pulses for the game/UI FSMs: press, release, click, long press and auto-repeat.
- Sits directly downstream of each debounce instance, in the same clock domain, so no input synchronizer is used.

Parameters:
LONG_CNT, 50000000, consecutive pressed samples needed for long_press (>=2)
REPEAT_CNT, 10000000, cycles between repeat pulses once long (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in  input  1  debounced button level, 1 = pressed
held  output  1  registered level, 1 while state is PRESS or LONG
press  output  1  1-cycle pulse, press accepted
release  output  1  1-cycle pulse, accepted press ended
click  output  1  1-cycle pulse, released before long_press fired
long_press  output  1  1-cycle pulse, hold reached LONG_CNT samples
repeat  output  1  1-cycle pulse, periodic while still held after long_press

Behaviour:
- Reset and outputs:
  - Reset is asynchronous and active-low; clock and reset ports are clk and reset_n.
  - While reset_n=0, every output is 0 immediately, state is LOCK and the counter is 0.
  - All outputs are registered; each pulse is high for exactly one cycle.
- Edge numbering: the "sample at edge k" is the value of in seen at posedge k.
- Counter: single counter cnt, width $clog2(max(LONG_CNT,REPEAT_CNT))+1, unsigned; it never wraps.
- LOCK:
  - Entered on reset.
  - in=1: stay in LOCK, no events. A button held through reset must be released first.
  - in=0: go to IDLE.
- IDLE:
  - in=1 at edge k: go to PRESS, cnt<=1, press=1 and held=1 after edge k.
- PRESS:
  - in=1: cnt<=cnt+1. When cnt==LONG_CNT-1 at the edge: go to LONG, long_press=1, cnt<=0. long_press therefore follows press by LONG_CNT-1 cycles.
  - in=0: go to IDLE, release=1 and click=1 in the same cycle, held=0.
- LONG:
  - in=1: cnt<=cnt+1. When cnt==REPEAT_CNT-1: repeat=1, cnt<=0. Only with BTN_AUTOREPEAT_EN; see Optional Feature.
  - in=0: go to IDLE, release=1, click=0, held=0.
- Simultaneous events:
  - Release takes priority over long_press and over repeat on the same edge. Example: PRESS with cnt==LONG_CNT-1 and in=0 gives click, not long_press.
  - A new press is accepted on the edge immediately after a release; there is no dead time beyond the one IDLE sample.
- Reset mid-hold: pulses are cancelled and no release is emitted. Re-arming requires in=0.
- Invalid parameters (LONG_CNT<2, REPEAT_CNT<1) cause an elaboration error via a generate-time check.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: LONG counts and emits repeat every REPEAT_CNT cycles while held. The first repeat comes REPEAT_CNT cycles after long_press.
- Undefined:
  - repeat is tied to 0 and the LONG state holds cnt static.
  - The REPEAT_CNT parameter is still accepted but unused.
  - All other behaviour is identical.

Test Plan (LONG_CNT=8, REPEAT_CNT=4, BTN_AUTOREPEAT_EN defined unless noted):
1. Short tap: in=1 sampled at edges 0..2, 0 at edge 3 -> press after edge 0; release and click after edge 3; no long_press; held high for cycles 0..2.
2. Long hold: in=1 at edges 0..15, 0 at 16 -> press@0, long_press@7, repeat@11 and @15, release@16, click never asserted.
3. Boundary: in=1 at edges 0..6, 0 at 7 -> click@7 and no long_press; then in=1 at edges 10..17 -> press@10, long_press@17.
4. Held through reset: in=1 before reset_n rises and kept high for 20 cycles -> no press, held=0. Then in=0 for 1 edge, then 1 -> press on that edge.
5. Async reset mid-LONG at edge 9 of a hold -> all outputs 0 before the next clk edge; no release emitted; state LOCK.
6. Macro undefined: repeat of scenario 2 -> press@0, long_press@7, release@16, repeat stays 0 throughout.
